// File: rtl/crank_wheel_gen.sv
// crank_wheel_gen: programmable N-minus-M crank wheel emulator with double-buffered config.
// Optional cam phase output enabled by defining CRANK_GEN_CAM_EN.
module crank_wheel_gen #(
    parameter int PW = 24,
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          load,
    input  logic [PW-1:0] cfg_period,
    input  logic [PW-1:0] cfg_high,
    input  logic [TW-1:0] cfg_teeth,
    input  logic [TW-1:0] cfg_missing,
    output logic          vr_out,
    output logic [TW-1:0] tooth_idx,
    output logic          rev_pulse,
    output logic          cfg_err,
`ifdef CRANK_GEN_CAM_EN
    output logic          cam_out,
`endif
    output logic          active
);
    typedef enum logic [1:0] {IDLE, RUN_TOOTH, RUN_GAP} state_t;
    state_t        state;
    logic [PW-1:0] sh_period, sh_high, ac_period, ac_high, cnt, cnt_nx;
    logic [TW-1:0] sh_teeth, sh_missing, ac_teeth, ac_missing, idx_nx;
    logic          cfg_valid, cfg_ok, boundary, wrap, start, nx_gap;
    assign cfg_ok   = cfg_period >= PW'(2) && cfg_high >= PW'(1) && cfg_high < cfg_period &&
                      cfg_teeth >= TW'(3) && cfg_missing <= cfg_teeth - TW'(2);
    assign cnt_nx   = cnt + PW'(1);
    assign idx_nx   = tooth_idx + TW'(1);
    assign boundary = cnt == ac_period - PW'(1);
    assign wrap     = boundary && tooth_idx == ac_teeth - TW'(1);
    assign start    = state == IDLE && ena && cfg_valid;
    assign nx_gap   = idx_nx >= ac_teeth - ac_missing;
`ifdef CRANK_GEN_CAM_EN
    logic phase;
    assign cam_out = phase && tooth_idx == '0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            tooth_idx <= '0;
            vr_out <= 1'b0;
            rev_pulse <= 1'b0;
            cfg_err <= 1'b0;
            active <= 1'b0;
            cfg_valid <= 1'b0;
            {sh_period, sh_high, sh_teeth, sh_missing} <= '0;
            {ac_period, ac_high, ac_teeth, ac_missing} <= '0;
`ifdef CRANK_GEN_CAM_EN
            phase <= 1'b0;
`endif
        end else begin
            cfg_err <= load && !cfg_ok;
            rev_pulse <= 1'b0;
            if (load && cfg_ok) begin
                {sh_period, sh_high, sh_teeth, sh_missing} <= {cfg_period, cfg_high, cfg_teeth, cfg_missing};
                cfg_valid <= 1'b1;
            end
            // Covers both sitting in IDLE and dropping out of a RUN state on ena=0.
            if (state == IDLE || !ena) begin
                state <= start ? RUN_TOOTH : IDLE;
                cnt <= '0;
                tooth_idx <= '0;
                vr_out <= start;
                active <= start;
                {ac_period, ac_high, ac_teeth, ac_missing} <= {sh_period, sh_high, sh_teeth, sh_missing};
`ifdef CRANK_GEN_CAM_EN
                phase <= 1'b0;
`endif
            end else if (wrap) begin
                cnt <= '0;
                tooth_idx <= '0;
                state <= RUN_TOOTH;
                vr_out <= 1'b1;
                rev_pulse <= 1'b1;
                {ac_period, ac_high, ac_teeth, ac_missing} <= {sh_period, sh_high, sh_teeth, sh_missing};
`ifdef CRANK_GEN_CAM_EN
                phase <= !phase;
`endif
            end else if (boundary) begin
                cnt <= '0;
                tooth_idx <= idx_nx;
                state <= nx_gap ? RUN_GAP : RUN_TOOTH;
                vr_out <= !nx_gap;
            end else begin
                cnt <= cnt_nx;
                vr_out <= state == RUN_TOOTH && cnt_nx < ac_high;
            end
        end
    end
endmodule

// File: tb/tb_crank_wheel_gen.sv
// tb_crank_wheel_gen: randomized bench against a revolution-position reference model.
module tb_crank_wheel_gen;
    logic        clk = 0, rst = 1, ena = 0, load = 0;
    logic [23:0] cfg_period = 0, cfg_high = 0;
    logic [7:0]  cfg_teeth = 0, cfg_missing = 0;
    logic        vr_out, rev_pulse, cfg_err, active;
    logic [7:0]  tooth_idx;
    int          vecs = 0, errs = 0;
`ifdef CRANK_GEN_CAM_EN
    logic cam_out;
`endif
    crank_wheel_gen dut (
        .clk(clk), .rst(rst), .ena(ena), .load(load),
        .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_teeth(cfg_teeth), .cfg_missing(cfg_missing),
        .vr_out(vr_out), .tooth_idx(tooth_idx), .rev_pulse(rev_pulse), .cfg_err(cfg_err),
`ifdef CRANK_GEN_CAM_EN
        .cam_out(cam_out),
`endif
        .active(active)
    );
    always #5 clk = ~clk;
    // Model: position r within the current revolution, revolution length = period*teeth.
    bit    m_run, m_valid, m_rev, m_err, m_phase;
    longint m_r;
    int    a_per, a_hi, a_tth, a_mis, s_per, s_hi, s_tth, s_mis;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic bit cfg_is_ok(int p, int h, int t, int m);
        return p >= 2 && h >= 1 && h < p && t >= 3 && m <= t - 2;
    endfunction
    task automatic model_edge();
        bit ok;
        if (rst) begin
            {m_run, m_valid, m_rev, m_err, m_phase} = '0;
            m_r = 0;
            {a_per, a_hi, a_tth, a_mis, s_per, s_hi, s_tth, s_mis} = '0;
            return;
        end
        ok = cfg_is_ok(int'(cfg_period), int'(cfg_high), int'(cfg_teeth), int'(cfg_missing));
        m_err = load && !ok;
        m_rev = 0;
        if (m_run && ena) begin
            m_r++;
            if (m_r == longint'(a_per) * a_tth) begin
                m_r = 0;
                {a_per, a_hi, a_tth, a_mis} = {s_per, s_hi, s_tth, s_mis};
                m_rev = 1;
                m_phase = !m_phase;
            end
        end else begin
            m_run = !m_run && ena && m_valid;
            m_r = 0;
            {a_per, a_hi, a_tth, a_mis} = {s_per, s_hi, s_tth, s_mis};
            m_phase = 0;
        end
        if (load && ok) begin
            {s_per, s_hi, s_tth, s_mis} = {int'(cfg_period), int'(cfg_high), int'(cfg_teeth), int'(cfg_missing)};
            m_valid = 1;
        end
    endtask
    task automatic compare_all();
        int idx, c;
        idx = m_run ? int'(m_r / a_per) : 0;
        c   = m_run ? int'(m_r % a_per) : 0;
        check("vr_out", vr_out, m_run && idx < a_tth - a_mis && c < a_hi);
        check("tooth_idx", tooth_idx, idx);
        check("rev_pulse", rev_pulse, m_rev);
        check("cfg_err", cfg_err, m_err);
        check("active", active, m_run);
`ifdef CRANK_GEN_CAM_EN
        check("cam_out", cam_out, m_phase && idx == 0);
`endif
    endtask
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask
    task automatic do_load(int p, int h, int t, int m);
        cfg_period = 24'(p); cfg_high = 24'(h); cfg_teeth = 8'(t); cfg_missing = 8'(m);
        load = 1;
        tick();
        load = 0;
    endtask
    task automatic run(int n);
        repeat (n) tick();
    endtask
    // Advance until the model reaches position r in a running revolution.
    task automatic run_to(longint r);
        bit hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            if (m_run && m_r == r) hit = 1;
            else tick();
        end
        check("run_to_timeout", hit, 1);
    endtask
    initial begin
        run(2);
        rst = 0;
        ena = 1;
        run(3);
        do_load(10, 4, 6, 1);
        run(200);
        do_load(1, 0, 6, 1);
        do_load(10, 10, 6, 1);
        do_load(10, 4, 6, 5);
        run(20);
        run_to(2 * 10);
        do_load(20, 4, 6, 1);
        run(200);
        run_to(longint'(a_per) * a_tth - 1);
        do_load(8, 3, 6, 2);
        run(300);
        run_to(3 * a_per + 2);
        ena = 0;
        tick();
        ena = 1;
        run(100);
        run_to(2 * a_per + 1);
        rst = 1;
        tick();
        rst = 0;
        run(20);
        do_load(1, 0, 3, 0);
        run(5);
        do_load(5, 1, 3, 0);
        run(60);
        for (int i = 0; i < 4000; i++) begin
            int p, t;
            rst = $urandom_range(0, 499) == 0;
            if ($urandom_range(0, 99) == 0) ena = !ena;
            if ($urandom_range(0, 39) == 0) begin
                p = $urandom_range(1, 12);
                t = $urandom_range(2, 8);
                cfg_period = 24'(p);
                cfg_high = 24'($urandom_range(0, p));
                cfg_teeth = 8'(t);
                cfg_missing = 8'($urandom_range(0, t));
                load = 1;
            end else load = 0;
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/crank_wheel_gen.md
Name: crank_wheel_gen

Overview:
Crank trigger-wheel emulator that generates the tooth pulse train the angle-capture path consumes on vr_in. It produces a programmable N-minus-M wheel: tooth period, high time, tooth count and missing-tooth count are all set at run time. It is used for closed-loop bench and self-test: its vr_out is looped into the capture filter and period counter in place of the real VR sensor. Configuration is double-buffered, and new settings take effect only on a revolution boundary, so the emitted wheel never glitches.

Parameters:
PW, 24, width of the tooth period and high-time fields in clk cycles; matches the period counter width.
TW, 8, width of the tooth count, missing-tooth count and tooth index fields.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ena  in  1  run enable; 1 = generate, 0 = idle
load  in  1  one-cycle strobe that samples cfg_* into the shadow registers
cfg_period  in  PW  tooth period in clk cycles
cfg_high  in  PW  tooth high time in clk cycles
cfg_teeth  in  TW  total tooth positions per revolution, missing teeth included (e.g. 60)
cfg_missing  in  TW  number of missing teeth at the end of the revolution (e.g. 2)
vr_out  out  1  generated tooth signal, registered
tooth_idx  out  TW  current tooth position, 0..cfg_teeth-1
rev_pulse  out  1  one-cycle pulse on entry to tooth 0 of every revolution after the first
cfg_err  out  1  one-cycle pulse when a load is rejected
active  out  1  1 while in a RUN state
cam_out  out  1  cam phase output; present only with CRANK_GEN_CAM_EN

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE.
  - All outputs 0.
  - Shadow and active config registers cleared; cfg_valid=0.
  - Reset asserted mid-revolution behaves the same: vr_out goes to 0 on the next edge.
- Config validity: a load is accepted only if all of the following hold:
  - cfg_period >= 2
  - 1 <= cfg_high < cfg_period
  - cfg_teeth >= 3
  - cfg_missing <= cfg_teeth-2
- Accepted load: values written to the shadow registers; pending=1; cfg_valid=1.
- Rejected load: cfg_err=1 for one cycle (the cycle after load); shadow registers unchanged.
- Shadow-to-active copy:
  - Immediately, when in IDLE.
  - Otherwise at the revolution boundary (cycle where tooth_idx wraps to 0); pending then clears.
  - Load and wrap in the same cycle: the wrap uses the old shadow; the new shadow applies at the next wrap.
- FSM states:
  - IDLE: cnt=0, tooth_idx=0, vr_out=0, active=0. If ena=1 and cfg_valid=1, go to RUN_TOOTH next cycle with cnt=0. If ena=1 and cfg_valid=0, remain in IDLE.
  - RUN_TOOTH: vr_out=1 while cnt<high, else 0.
  - RUN_GAP: vr_out=0 throughout.
- cnt runs 0..period-1 in both RUN states; tooth boundary at cnt==period-1.
- At a tooth boundary:
  - cnt <= 0.
  - tooth_idx <= tooth_idx+1, or wraps to 0 at cfg_teeth-1.
  - Next state is RUN_GAP if the new idx >= teeth-missing, else RUN_TOOTH.
  - missing=0: RUN_GAP is never entered.
- rev_pulse=1 in the cycle after the wrap (the first cycle of tooth 0). It is not asserted at start from IDLE.
- Latency: the edge that samples ena=1 from IDLE makes the first cycle vr_out=1. The first rising vr_out edge occurs one clk after ena is sampled.
- ena=0 in any RUN state: IDLE on the next edge; vr_out=0; tooth_idx=0. No partial-tooth completion.
- Widths: cnt is PW bits and cannot overflow, because the compare uses period-1 with period>=2. tooth_idx compares are TW-bit unsigned.

Optional Feature:
Macro CRANK_GEN_CAM_EN.
- Defined:
  - A phase flip-flop toggles at every revolution wrap; it resets to 0 and clears in IDLE.
  - cam_out=1 while phase==1 and tooth_idx==0; otherwise 0.
  - This gives one cam pulse per two revolutions, one tooth period long.
- Undefined: no cam_out port and no phase register; all other behaviour identical.

Test Plan:
1. Reset, load period=10, high=4, teeth=6, missing=1, then ena=1.
   -> vr_out pattern per revolution: 5 teeth of 4 high / 6 low, then 10 low.
   -> tooth_idx 0..5.
   -> rev_pulse one cycle at cycle 60 after start; not at start.
2. Load period=1, or high=10 with period=10, or missing=5 with teeth=6.
   -> cfg_err one cycle each time.
   -> Output unchanged from the prior valid config; in IDLE with no prior config, ena=1 leaves active=0.
3. While running config 1, load period=20 at tooth 2.
   -> Period stays 10 until the wrap; the next revolution uses 20.
   -> Load coinciding with the wrap cycle takes effect one revolution later.
4. Deassert ena at cnt=2 of tooth 3.
   -> Next edge: vr_out=0, tooth_idx=0, active=0.
   -> Re-enable: restarts at tooth 0 with no rev_pulse.
5. Assert rst mid-high-pulse.
   -> All outputs 0 next cycle.
   -> ena=1 without a load stays IDLE (config cleared).
6. CRANK_GEN_CAM_EN defined, config 1.
   -> cam_out high for cycles 60..69, low for 120..129, high again at 180..189.
   -> Undefined build: compiles with no cam_out port.
